// File: rtl/riscv_pkg.sv
// Shared definitions for the machine-mode CSR file and trap controller:
// CSR addresses, cause codes, status/enable bit positions and data-memory op encoding.
package riscv_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

   localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

   localparam logic [4:0] CAUSE_ILLEGAL          = 5'd2;
   localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
   localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
   localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;
   localparam logic [4:0] CAUSE_ECALL_M          = 5'd11;
   localparam logic [4:0] CAUSE_IRQ_TIMER        = 5'd7;
   localparam logic [4:0] CAUSE_IRQ_EXTERNAL     = 5'd11;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MEIE     = 11;
   localparam int MIE_MTIE     = 7;

   localparam int DMEM_STORE_BIT = 2;
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } dmem_size_e;

   // Size encodings 10 and 11 are both word accesses.
   function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      if (size == SIZE_BYTE)
         return 1'b0;
      else if (size == SIZE_HALF)
         return addr_lo[0];
      else
         return addr_lo != 2'b00;
   endfunction

endpackage

// File: rtl/riscv_trap_arbiter.sv
// Combinational trap priority encoder: interrupts (gated by MIE and mie) first,
// then breakpoint, illegal instruction, ecall and misaligned data access.
module riscv_trap_arbiter
   import riscv_pkg::*;
(
   input  logic       mstatus_mie,
   input  logic       meie,
   input  logic       mtie,
   input  logic       meip,
   input  logic       mtip,
   input  logic       breakpoint,
   input  logic       illegal_instruction,
   input  logic       ecall,
   input  logic [2:0] dmem_op,
   input  logic [1:0] addr_lo,
   output logic       trap,
   output logic       is_interrupt,
   output logic [4:0] cause
);

   logic misaligned;

   assign misaligned = access_misaligned(dmem_op[1:0], addr_lo);

   always_comb begin
      trap         = 1'b1;
      is_interrupt = 1'b0;
      cause        = 5'd0;
      if (mstatus_mie && meie && meip) begin
         is_interrupt = 1'b1;
         cause        = CAUSE_IRQ_EXTERNAL;
      end else if (mstatus_mie && mtie && mtip) begin
         is_interrupt = 1'b1;
         cause        = CAUSE_IRQ_TIMER;
      end else if (breakpoint) begin
         cause = CAUSE_BREAKPOINT;
      end else if (illegal_instruction) begin
         cause = CAUSE_ILLEGAL;
      end else if (ecall) begin
         cause = CAUSE_ECALL_M;
      end else if (misaligned) begin
         cause = dmem_op[DMEM_STORE_BIT] ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
      end else begin
         trap = 1'b0;
      end
   end

endmodule

// File: rtl/riscv_trap_control.sv
// Machine-mode CSR file and trap controller for the RV32 hart: CSR reads/writes,
// trap entry/mret bookkeeping, cycle/instret counters and fetch redirect targets.
module riscv_trap_control
   import riscv_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [11:0]   csr,
   input  logic [4095:0] csr_,
   output logic [31:0]   csr_value,
   input  logic [31:0]   csr_wb,
   input  logic [31:0]   pc,
   input  logic          imem_data_ready,
   input  logic [2:0]    dmem_op,
   input  logic [31:0]   addr,
   input  logic          illegal_instruction,
   input  logic          breakpoint,
   input  logic          ecall,
   input  logic          mret,
   input  logic          wfi,
   input  logic          hardware_irq,
   input  logic          timer_irq,
   output logic          trap,
   output logic [31:0]   trap_target,
   output logic [31:0]   mret_target
);

   logic        mstatus_mie, mstatus_mpie;
   logic        mie_meie, mie_mtie;
   logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [63:0] mcycle_q, minstret_q;
   logic [63:0] mcycle_nxt, minstret_nxt;
   logic        is_interrupt;
   logic [4:0]  cause;
   logic        wr_en;
   logic        unused_strobes;

   // Only a handful of strobe bits address implemented CSRs.
   assign unused_strobes = ^csr_;

   riscv_trap_arbiter u_arbiter (
      .mstatus_mie         (mstatus_mie),
      .meie                (mie_meie),
      .mtie                (mie_mtie),
      .meip                (hardware_irq),
      .mtip                (timer_irq),
      .breakpoint          (breakpoint),
      .illegal_instruction (illegal_instruction),
      .ecall               (ecall),
      .dmem_op             (dmem_op),
      .addr_lo             (addr[1:0]),
      .trap                (trap),
      .is_interrupt        (is_interrupt),
      .cause               (cause)
   );

   assign wr_en       = imem_data_ready & ~trap;
   assign mret_target = mepc_q;

   always_comb begin
      trap_target = {mtvec_q[31:2], 2'b00};
      if (is_interrupt && mtvec_q[1:0] == 2'b01)
         trap_target = {mtvec_q[31:2], 2'b00} + {25'd0, cause, 2'b00};
   end

   always_comb begin
      case (csr)
         CSR_MSTATUS:               csr_value = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
         CSR_MISA:                  csr_value = MISA_VALUE;
         CSR_MIE:                   csr_value = {20'd0, mie_meie, 3'd0, mie_mtie, 7'd0};
         CSR_MTVEC:                 csr_value = mtvec_q;
         CSR_MSCRATCH:              csr_value = mscratch_q;
         CSR_MEPC:                  csr_value = mepc_q;
         CSR_MCAUSE:                csr_value = mcause_q;
         CSR_MTVAL:                 csr_value = mtval_q;
         CSR_MIP:                   csr_value = {20'd0, hardware_irq, 3'd0, timer_irq, 7'd0};
         CSR_MCYCLE, CSR_CYCLE:     csr_value = mcycle_q[31:0];
         CSR_MCYCLEH, CSR_CYCLEH:   csr_value = mcycle_q[63:32];
         CSR_MINSTRET, CSR_INSTRET: csr_value = minstret_q[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: csr_value = minstret_q[63:32];
         default:                   csr_value = 32'd0;
      endcase
   end

   // A committed write to either half of a counter replaces that cycle's increment.
   always_comb begin
      if (wr_en && (csr_[CSR_MCYCLE] || csr_[CSR_MCYCLEH]))
         mcycle_nxt = mcycle_q;
      else
         mcycle_nxt = mcycle_q + 64'd1;
      if (wr_en && csr_[CSR_MCYCLE])  mcycle_nxt[31:0]  = csr_wb;
      if (wr_en && csr_[CSR_MCYCLEH]) mcycle_nxt[63:32] = csr_wb;

      if (wr_en && !(csr_[CSR_MINSTRET] || csr_[CSR_MINSTRETH]))
         minstret_nxt = minstret_q + 64'd1;
      else
         minstret_nxt = minstret_q;
      if (wr_en && csr_[CSR_MINSTRET])  minstret_nxt[31:0]  = csr_wb;
      if (wr_en && csr_[CSR_MINSTRETH]) minstret_nxt[63:32] = csr_wb;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_meie     <= 1'b0;
         mie_mtie     <= 1'b0;
         mtvec_q      <= 32'd0;
         mscratch_q   <= 32'd0;
         mepc_q       <= 32'd0;
         mcause_q     <= 32'd0;
         mtval_q      <= 32'd0;
         mcycle_q     <= 64'd0;
         minstret_q   <= 64'd0;
      end else begin
         mcycle_q   <= mcycle_nxt;
         minstret_q <= minstret_nxt;
         if (imem_data_ready && trap) begin
            // An interrupt that wakes a wfi resumes after the wfi, not on it.
            mepc_q   <= (is_interrupt && wfi) ? {pc[31:2] + 30'd1, 2'b00} : {pc[31:2], 2'b00};
            mcause_q <= {is_interrupt, 26'd0, cause};
            if (!is_interrupt && (cause == CAUSE_LOAD_MISALIGNED || cause == CAUSE_STORE_MISALIGNED))
               mtval_q <= addr;
            else if (!is_interrupt && cause == CAUSE_BREAKPOINT)
               mtval_q <= pc;
            else
               mtval_q <= 32'd0;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (wr_en) begin
            if (csr_[CSR_MSTATUS]) begin
               mstatus_mie  <= csr_wb[MSTATUS_MIE];
               mstatus_mpie <= csr_wb[MSTATUS_MPIE];
            end
            if (csr_[CSR_MIE]) begin
               mie_meie <= csr_wb[MIE_MEIE];
               mie_mtie <= csr_wb[MIE_MTIE];
            end
            if (csr_[CSR_MTVEC])    mtvec_q    <= {csr_wb[31:2], (csr_wb[1:0] == 2'b01) ? 2'b01 : 2'b00};
            if (csr_[CSR_MSCRATCH]) mscratch_q <= csr_wb;
            if (csr_[CSR_MEPC])     mepc_q     <= {csr_wb[31:2], 2'b00};
            if (csr_[CSR_MCAUSE])   mcause_q   <= csr_wb;
            if (csr_[CSR_MTVAL])    mtval_q    <= csr_wb;
            if (mret) begin
               mstatus_mie  <= mstatus_mpie;
               mstatus_mpie <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_riscv_trap_control.sv
// Bench for riscv_trap_control: a spec-level CSR/trap model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_riscv_trap_control;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [11:0]   csr = 12'h0;
   logic [4095:0] csr_we = '0;
   logic [31:0]   csr_value;
   logic [31:0]   csr_wb = 32'h0;
   logic [31:0]   pc = 32'h0;
   logic          imem_data_ready = 1'b0;
   logic [2:0]    dmem_op = 3'b000;
   logic [31:0]   addr = 32'h0;
   logic          illegal_instruction = 1'b0, breakpoint = 1'b0, ecall = 1'b0;
   logic          mret = 1'b0, wfi = 1'b0, hardware_irq = 1'b0, timer_irq = 1'b0;
   logic          trap;
   logic [31:0]   trap_target, mret_target;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   riscv_trap_control dut (
      .clk(clk), .rst(rst), .csr(csr), .csr_(csr_we), .csr_value(csr_value), .csr_wb(csr_wb),
      .pc(pc), .imem_data_ready(imem_data_ready), .dmem_op(dmem_op), .addr(addr),
      .illegal_instruction(illegal_instruction), .breakpoint(breakpoint), .ecall(ecall),
      .mret(mret), .wfi(wfi), .hardware_irq(hardware_irq), .timer_irq(timer_irq),
      .trap(trap), .trap_target(trap_target), .mret_target(mret_target)
   );

   always #5 clk = ~clk;

   // Architectural model state
   logic        m_mie_b = 0, m_mpie = 0;
   logic [31:0] m_mie_r = 0, m_mtvec = 0, m_mscratch = 0, m_mepc = 0, m_mcause = 0, m_mtval = 0;
   logic [63:0] m_cycle = 0, m_instret = 0;

   function automatic bit f_misaligned();
      if (dmem_op[1:0] == 2'b00) return 0;
      if (dmem_op[1:0] == 2'b01) return (addr % 2) != 0;
      return (addr % 4) != 0;
   endfunction

   // -1: no trap; 0..31: exception cause; 32+n: interrupt cause n
   function automatic int f_code();
      if (m_mie_b && m_mie_r[11] && hardware_irq) return 32 + 11;
      if (m_mie_b && m_mie_r[7] && timer_irq)     return 32 + 7;
      if (breakpoint)          return 3;
      if (illegal_instruction) return 2;
      if (ecall)               return 11;
      if (f_misaligned())      return dmem_op[2] ? 6 : 4;
      return -1;
   endfunction

   function automatic logic [31:0] f_target();
      int c = f_code();
      logic [31:0] base = m_mtvec & ~32'h3;
      if (c >= 32 && m_mtvec[1:0] == 2'b01) return base + 32'(4 * (c - 32));
      return base;
   endfunction

   function automatic logic [31:0] f_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (m_mie_b ? 32'h8 : 0) | (m_mpie ? 32'h80 : 0);
         12'h301: return 32'h4000_0100;
         12'h304: return m_mie_r;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return (hardware_irq ? 32'h800 : 0) | (timer_irq ? 32'h80 : 0);
         12'hB00, 12'hC00: return m_cycle[31:0];
         12'hB80, 12'hC80: return m_cycle[63:32];
         12'hB02, 12'hC02: return m_instret[31:0];
         12'hB82, 12'hC82: return m_instret[63:32];
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit f_wr(input int a);
      return imem_data_ready && f_code() < 0 && csr_we[a];
   endfunction

   function automatic logic [63:0] f_cycle_next();
      logic [63:0] v = (f_wr(12'hB00) || f_wr(12'hB80)) ? m_cycle : m_cycle + 1;
      if (f_wr(12'hB00)) v[31:0]  = csr_wb;
      if (f_wr(12'hB80)) v[63:32] = csr_wb;
      return v;
   endfunction

   function automatic logic [63:0] f_instret_next();
      logic [63:0] v = m_instret;
      if (imem_data_ready && f_code() < 0) v = v + 1;
      if (f_wr(12'hB02) || f_wr(12'hB82)) v = m_instret;
      if (f_wr(12'hB02)) v[31:0]  = csr_wb;
      if (f_wr(12'hB82)) v[63:32] = csr_wb;
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mie_b <= 0; m_mpie <= 0; m_mie_r <= 0; m_mtvec <= 0; m_mscratch <= 0;
         m_mepc <= 0; m_mcause <= 0; m_mtval <= 0; m_cycle <= 0; m_instret <= 0;
      end else begin
         m_cycle   <= f_cycle_next();
         m_instret <= f_instret_next();
         if (imem_data_ready && f_code() >= 0) begin
            m_mepc   <= ((f_code() >= 32 && wfi) ? pc + 4 : pc) & ~32'h3;
            m_mcause <= (f_code() >= 32) ? (32'h8000_0000 | 32'(f_code() - 32)) : 32'(f_code());
            m_mtval  <= (f_code() == 4 || f_code() == 6) ? addr : (f_code() == 3 ? pc : 32'h0);
            m_mpie   <= m_mie_b;
            m_mie_b  <= 0;
         end else if (imem_data_ready) begin
            if (mret) begin
               m_mie_b <= m_mpie;
               m_mpie  <= 1;
            end else if (csr_we[12'h300]) begin
               m_mie_b <= csr_wb[3];
               m_mpie  <= csr_wb[7];
            end
            if (csr_we[12'h304]) m_mie_r    <= csr_wb & 32'h880;
            if (csr_we[12'h305]) m_mtvec    <= (csr_wb & ~32'h3) | ((csr_wb[1:0] == 2'b01) ? 32'h1 : 32'h0);
            if (csr_we[12'h340]) m_mscratch <= csr_wb;
            if (csr_we[12'h341]) m_mepc     <= csr_wb & ~32'h3;
            if (csr_we[12'h342]) m_mcause   <= csr_wb;
            if (csr_we[12'h343]) m_mtval    <= csr_wb;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_trap", {31'd0, trap}, (f_code() >= 0) ? 32'd1 : 32'd0);
         check("model_trap_target", trap_target, f_target());
         check("model_mret_target", mret_target, m_mepc);
         check("model_csr_value", csr_value, f_read(csr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      imem_data_ready = 0; illegal_instruction = 0; breakpoint = 0; ecall = 0;
      mret = 0; wfi = 0; hardware_irq = 0; timer_irq = 0; dmem_op = 3'b000; csr_we = '0;
   endtask

   task automatic commit();
      imem_data_ready = 1;
      tick();
      clr();
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] v);
      csr_we = '0;
      csr_we[a] = 1'b1;
      csr_wb = v;
      commit();
   endtask

   task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
      csr = a;
      #1;
      check(name, csr_value, exp);
   endtask

   initial begin
      logic [63:0] cyc0, ins0;
      tick();
      tick();
      rst = 0;
      chk_en = 1;

      // Reset state
      rd_check("misa", 12'h301, 32'h4000_0100);
      rd_check("mstatus_reset", 12'h300, 32'h0000_1800);
      check("trap_target_reset", trap_target, 32'h0);
      check("mret_target_reset", mret_target, 32'h0);

      // Direct-mode exception; the simultaneous mscratch write is dropped
      wr(12'h305, 32'h100);
      pc = 32'h40; illegal_instruction = 1;
      csr_we[12'h340] = 1'b1; csr_wb = 32'hDEAD_BEEF;
      #1;
      check("illegal_trap", {31'd0, trap}, 32'd1);
      check("illegal_target", trap_target, 32'h100);
      commit();
      rd_check("illegal_mepc", 12'h341, 32'h40);
      rd_check("illegal_mcause", 12'h342, 32'h2);
      rd_check("illegal_mtval", 12'h343, 32'h0);
      rd_check("dropped_write", 12'h340, 32'h0);

      // Vectored timer interrupt
      wr(12'h305, 32'h201);
      wr(12'h304, 32'h880);
      wr(12'h300, 32'h8);
      timer_irq = 1;
      #1;
      check("timer_target", trap_target, 32'h21C);
      commit();
      rd_check("timer_mcause", 12'h342, 32'h8000_0007);
      rd_check("timer_mstatus", 12'h300, 32'h0000_1880);

      // Misaligned accesses
      dmem_op = 3'b010; addr = 32'h1002;
      commit();
      rd_check("ld_mis_mcause", 12'h342, 32'h4);
      rd_check("ld_mis_mtval", 12'h343, 32'h1002);
      dmem_op = 3'b101; addr = 32'h1001;
      commit();
      rd_check("st_mis_mcause", 12'h342, 32'h6);
      rd_check("st_mis_mtval", 12'h343, 32'h1001);
      dmem_op = 3'b010; addr = 32'h1004;
      #1;
      check("aligned_no_trap", {31'd0, trap}, 32'd0);
      clr();

      // mret
      wr(12'h341, 32'h81);
      rd_check("mepc_forced", 12'h341, 32'h80);
      wr(12'h300, 32'h80);
      mret = 1;
      #1;
      check("mret_target", mret_target, 32'h80);
      commit();
      rd_check("mret_mstatus", 12'h300, 32'h0000_1888);

      // Priority among exceptions, breakpoint mtval
      pc = 32'h300; breakpoint = 1; illegal_instruction = 1; ecall = 1;
      commit();
      rd_check("bp_mcause", 12'h342, 32'h3);
      rd_check("bp_mtval", 12'h343, 32'h300);
      ecall = 1;
      commit();
      rd_check("ecall_mcause", 12'h342, 32'hB);

      // External beats timer; wfi wake-up stores pc+4
      wr(12'h300, 32'h8);
      pc = 32'h200; hardware_irq = 1; timer_irq = 1; wfi = 1;
      #1;
      check("ext_target", trap_target, 32'h22C);
      commit();
      rd_check("wfi_mepc", 12'h341, 32'h204);
      rd_check("ext_mcause", 12'h342, 32'h8000_000B);
      timer_irq = 1;
      #1;
      check("masked_no_trap", {31'd0, trap}, 32'd0);
      rd_check("mip_timer", 12'h344, 32'h80);
      clr();

      // Counters
      csr = 12'hB00;
      tick();
      cyc0 = m_cycle;
      ins0 = m_instret;
      repeat (5) tick();
      rd_check("mcycle_plus5", 12'hB00, cyc0[31:0] + 32'd5);
      rd_check("minstret_hold", 12'hB02, ins0[31:0]);
      wr(12'hB02, 32'h7);
      rd_check("minstret_write", 12'hB02, 32'h7);
      rd_check("instret_alias", 12'hC02, 32'h7);
      wr(12'h7C0, 32'h1234);
      rd_check("unimpl_read", 12'h7C0, 32'h0);
      tick();

      // Asynchronous reset mid-cycle
      rst = 1;
      rd_check("rst_mepc", 12'h341, 32'h0);
      rd_check("rst_mtvec", 12'h305, 32'h0);
      check("rst_trap_target", trap_target, 32'h0);
      check("rst_mret_target", mret_target, 32'h0);
      illegal_instruction = 1;
      #1;
      check("rst_trap_exc", {31'd0, trap}, 32'd1);
      clr();
      tick();
      rst = 0;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/riscv_trap_control.md
# riscv_trap_control

Machine-mode CSR file and trap controller for the single-issue RV32 hart. It sits beside the datapath. It decodes synchronous exceptions and interrupts, selects the trap and mret targets the hart's fetch mux uses, and serves CSR reads and writes for Zicsr instructions. Only M-mode is supported; there is no privilege switching.

## Interface
Parameters: none.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- csr  in  12  CSR address of the current instruction; selects csr_value
- csr_  in  4096  one-hot CSR write strobe; bit n set writes csr_wb into CSR n
- csr_value  out  32  combinational read data of CSR `csr`
- csr_wb  in  32  CSR write data
- pc  in  32  address of the instruction currently executing
- imem_data_ready  in  1  commit strobe; all state updates occur only on clk edges where this is high
- dmem_op  in  3  {store, size[1:0]}; size 00=byte, 01=half, 10/11=word; datapath drives 000 when idle
- addr  in  32  data-memory address
- illegal_instruction, breakpoint, ecall, mret, wfi  in  1 each  decoded events from the datapath
- hardware_irq, timer_irq  in  1 each  level-sensitive interrupt lines
- trap  out  1  take trap this cycle
- trap_target  out  32  handler address
- mret_target  out  32  equals mepc

## Operation
- mip (0x344) is read-only: MEIP[11]=hardware_irq, MTIP[7]=timer_irq.
- mie (0x304): only bits 11 and 7 are writable.
- mstatus (0x300): MIE[3] and MPIE[7] are writable. MPP[12:11] reads 11. All other bits read 0.
- Other writable CSRs: mtvec (0x305; mode[1:0] with 00=direct, 01=vectored, 1x read back as 00), mscratch (0x340), mepc (0x341, bits [1:0] forced 0), mcause (0x342), mtval (0x343).
- Counters: mcycle/mcycleh (0xB00/0xB80) increment every clk. minstret/minstreth (0xB02/0xB82) increment on each commit without trap. These also have read-only aliases at 0xC00/0xC80/0xC02/0xC82.
- Constant CSRs: misa=0x40000100; mvendorid, marchid, mimpid, mhartid read 0. Unimplemented addresses read 0, and writes to them are ignored.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0. Load raises cause 4, store raises cause 6.
- Trap priority (highest first):
  - external interrupt (cause 11), only if mstatus.MIE & mie[11] & mip[11]
  - timer interrupt (cause 7), only if mstatus.MIE & mie[7] & mip[7]
  - breakpoint (3)
  - illegal instruction (2)
  - ecall (11)
  - load/store misaligned (4/6)
- trap is the combinational OR of all the above conditions.
- trap_target = mtvec.BASE. In vectored mode, interrupts instead go to BASE + 4*cause.
- On a trap commit:
  - mepc <= pc. Exception: an interrupt taken while wfi is high stores pc+4.
  - mcause <= {interrupt, cause}.
  - mtval <= addr for misaligned, pc for breakpoint, 0 otherwise.
  - MPIE <= MIE; MIE <= 0.
- The hart suppresses architectural effects of the instruction at pc when trap is high; that instruction re-executes after mret.
- mret commit without trap: MIE <= MPIE; MPIE <= 1.
- wfi: the hart holds pc. Wake-up is on any (mie & mip) != 0, regardless of MIE. Control needs no wfi state.
- Simultaneous events on the same commit:
  - trap beats a CSR write or mret; the write is dropped.
  - A CSR write to a counter beats that cycle's increment.

## Timing
- csr_value, trap, trap_target and mret_target are combinational from inputs and current state (zero latency).
- CSR and trap state updates take effect on the next clk edge with imem_data_ready=1. With imem_data_ready=0, only mcycle advances.
- Reset (asynchronous, valid mid-operation) clears every CSR and counter to 0. Resulting outputs: trap_target=0 and mret_target=0. trap=0 unless an exception input is asserted.

## Structure
- Shared package riscv_pkg holds:
  - CSR address constants
  - cause codes
  - mstatus/mie bit indices
  - dmem_op encoding
- One sub-module, riscv_trap_arbiter, takes the event and interrupt lines and produces trap, is_interrupt and cause[4:0]. It is purely combinational.

## Test plan
- Reset, then read misa and mstatus -> 0x40000100 and 0x00001800. trap_target=0.
- Write mtvec=0x100, assert illegal_instruction at pc=0x40 -> trap=1, trap_target=0x100. After commit: mepc=0x40, mcause=2, mtval=0.
- mtvec=0x201 (vectored), mie=0x880, mstatus=0x8, raise timer_irq -> trap_target=0x21C. After commit: mcause=0x80000007, mstatus.MIE=0, MPIE=1.
- Word load with dmem_op=3'b010, addr=0x1002 -> mcause=4, mtval=0x1002. Store half (3'b101) at 0x1001 -> mcause=6.
- mret with mepc=0x80 and MPIE=1 -> mret_target=0x80. After commit: MIE=1, MPIE=1.
- Hold imem_data_ready=0 for 5 clocks -> mcycle+5, minstret unchanged. Write minstret=7 on a commit -> reads 7, not 8.
